// File: rtl/fpu_exp_sub_arbiter.sv
// fpu_exp_sub_arbiter
// Shares one exponent subtractor (x + ~y + 1) among NUM_REQ FPU add/sub
// requesters. A round-robin grant picks one request in IDLE and latches its
// operands. The block then returns |A - B| and a swap flag (A < B) to the
// mantissa-alignment stage.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester request valid
//   i_exp_a/b    packed exponents, requester k at [k*SIZE_EXP +: SIZE_EXP]
//   o_req_ready  one-hot grant (IDLE only)
//   o_rsp_valid  response valid (RESP state)
//   o_rsp_id     owner of the response
//   o_rsp_diff   |A - B|
//   o_rsp_swap   1 when A < B
//   i_rsp_ready  consumer ready
//   o_busy       high in every state except IDLE
module fpu_exp_sub_arbiter #(
   parameter  int NUM_REQ  = 4,
   parameter  int SIZE_EXP = 8,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ*SIZE_EXP-1:0]  i_exp_a,
   input  logic [NUM_REQ*SIZE_EXP-1:0]  i_exp_b,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic                         o_rsp_valid,
   output logic [ID_W-1:0]              o_rsp_id,
   output logic [SIZE_EXP-1:0]          o_rsp_diff,
   output logic                         o_rsp_swap,
   input  logic                         i_rsp_ready,
   output logic                         o_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t              state, state_next;
   logic [ID_W-1:0]     rr_ptr;
   logic [SIZE_EXP-1:0] a_reg, b_reg;
   logic [ID_W-1:0]     id_reg;
   logic [SIZE_EXP-1:0] sum_reg;
   logic                carry_reg;
   // PASS1 spans two cycles: the first registers the subtractor result,
   // the second acts on the registered carry.
   logic                pass1_eval;
   logic [SIZE_EXP-1:0] diff_reg;
   logic                swap_reg;

   // ---------------- round-robin grant ----------------
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_id;
   logic                grant_found;
   logic [ID_W-1:0]     scan_idx;

   always_comb begin
      grant       = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!grant_found && i_req_valid[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_id        = scan_idx;
            grant_found     = 1'b1;
         end
      end
   end

   wire accept = (state == IDLE) && grant_found;

   // ---------------- the single shared subtractor ----------------
   // Operands are reversed only in PASS2; the carry-out is the sole
   // ordering test (carry = 1 means x >= y).
   logic [SIZE_EXP-1:0] sub_x, sub_y;
   logic [SIZE_EXP:0]   sub_sum;

   assign sub_x   = (state == PASS2) ? b_reg : a_reg;
   assign sub_y   = (state == PASS2) ? a_reg : b_reg;
   assign sub_sum = {1'b0, sub_x} + {1'b0, ~sub_y} + (SIZE_EXP+1)'(1);

   // ---------------- state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         id_reg     <= '0;
         sum_reg    <= '0;
         carry_reg  <= 1'b0;
         pass1_eval <= 1'b0;
         diff_reg   <= '0;
         swap_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg      <= i_exp_a[int'(grant_id)*SIZE_EXP +: SIZE_EXP];
                  b_reg      <= i_exp_b[int'(grant_id)*SIZE_EXP +: SIZE_EXP];
                  id_reg     <= grant_id;
                  rr_ptr     <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                  pass1_eval <= 1'b0;
               end
            end
            PASS1: begin
               if (!pass1_eval) begin
                  sum_reg    <= sub_sum[SIZE_EXP-1:0];
                  carry_reg  <= sub_sum[SIZE_EXP];
                  pass1_eval <= 1'b1;
               end else if (carry_reg) begin
                  diff_reg <= sum_reg;
                  swap_reg <= 1'b0;
               end
            end
            PASS2: begin
               diff_reg <= sub_sum[SIZE_EXP-1:0];
               swap_reg <= 1'b1;
            end
            default: ;  // RESP: everything held for backpressure
         endcase
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept) state_next = PASS1;
         PASS1: if (pass1_eval) state_next = carry_reg ? RESP : PASS2;
         PASS2: state_next = RESP;
         RESP:  if (i_rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      o_req_ready = '0;
      o_rsp_valid = 1'b0;
      o_busy      = 1'b1;
      case (state)
         IDLE: begin
            o_busy      = 1'b0;
            // Gated by reset so no grant is visible while reset is held.
            o_req_ready = i_rst_n ? grant : '0;
         end
         RESP:    o_rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign o_rsp_id   = id_reg;
   assign o_rsp_diff = diff_reg;
   assign o_rsp_swap = swap_reg;

endmodule

// File: tb/tb_fpu_exp_sub_arbiter.sv
module tb_fpu_exp_sub_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] diff;
      logic       swap;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] exp_a, exp_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_diff;
   logic        rsp_swap;
   logic        rsp_ready;
   logic        busy;

   int errors    = 0;
   int checks    = 0;
   int rsp_count = 0;
   rsp_t sb_q[$];

   always #5 clk = ~clk;

   fpu_exp_sub_arbiter #(.NUM_REQ(4), .SIZE_EXP(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_exp_a     (exp_a),
      .i_exp_b     (exp_b),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_id    (rsp_id),
      .o_rsp_diff  (rsp_diff),
      .o_rsp_swap  (rsp_swap),
      .i_rsp_ready (rsp_ready),
      .o_busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference: ordinary magnitude comparison, independent of carry tricks.
   function automatic rsp_t model(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b);
      rsp_t r;
      r.id   = id;
      r.swap = (a < b);
      r.diff = r.swap ? (b - a) : (a - b);
      return r;
   endfunction

   // Monitor: one-hot grant every cycle; pop/compare on each handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("grant_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
         if (rsp_valid && rsp_ready) begin
            rsp_t e;
            check("rsp_expected", {31'd0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("rsp_id",   {30'd0, rsp_id},   {30'd0, e.id});
               check("rsp_diff", {24'd0, rsp_diff}, {24'd0, e.diff});
               check("rsp_swap", {31'd0, rsp_swap}, {31'd0, e.swap});
               $display("rsp id=%0d diff=%02h swap=%0d (exp id=%0d diff=%02h swap=%0d)",
                        rsp_id, rsp_diff, rsp_swap, e.id, e.diff, e.swap);
            end
            rsp_count++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Single requester op with latency measurement from the accept edge.
   task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input int exp_lat);
      int lat;
      bit got;
      exp_a = $urandom;
      exp_b = $urandom;
      exp_a[id*8 +: 8] = a;
      exp_b[id*8 +: 8] = b;
      req_valid = 4'b0001 << id;
      sb_q.push_back(model(2'(id), a, b));
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1;
      end
      check("grant_seen", {31'd0, got}, 32'd1);
      @(posedge clk);  // accept edge
      #1;
      req_valid = 4'b0000;
      exp_a = $urandom;  // post-accept garbage must be ignored
      exp_b = $urandom;
      lat = 0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(posedge clk);
         lat++;
         #1;
         if (rsp_valid) got = 1;
      end
      check("latency", lat, exp_lat);
      @(posedge clk);  // handshake edge (rsp_ready high)
      #1;
   endtask

   task automatic wait_rsp_count(input int target, input int budget);
      bit done;
      done = 0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clk);
         if (rsp_count >= target) done = 1;
      end
      check("rsp_count_reached", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int base;
      rsp_t e;
      rst_n     = 1'b0;
      req_valid = 4'hF;
      exp_a     = 32'h0;
      exp_b     = 32'h0;
      rsp_ready = 1'b1;
      #3;
      // reset state
      check("rst_req_ready", {28'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_rsp_id",    {30'd0, rsp_id},    32'd0);
      check("rst_rsp_diff",  {24'd0, rsp_diff},  32'd0);
      check("rst_rsp_swap",  {31'd0, rsp_swap},  32'd0);
      req_valid = 4'h0;
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed single ops
      do_op(0, 8'h85, 8'h80, 2);
      do_op(2, 8'h7F, 8'h82, 3);
      do_op(1, 8'h90, 8'h90, 2);
      do_op(1, 8'hFF, 8'h00, 2);
      do_op(1, 8'h00, 8'hFF, 3);
      do_op(1, 8'h01, 8'h00, 2);
      check("queue_empty_directed", sb_q.size(), 0);

      // round robin from a fresh reset: all four requesters always valid
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_a[k*8 +: 8] = 8'h20 + 8'(k);
         exp_b[k*8 +: 8] = k[0] ? 8'h30 : 8'h10;
      end
      for (int n = 0; n < 6; n++) begin
         int k;
         k = n % 4;
         sb_q.push_back(model(2'(k), 8'h20 + 8'(k), k[0] ? 8'h30 : 8'h10));
      end
      base = rsp_count;
      req_valid = 4'hF;
      wait_rsp_count(base + 6, 100);
      #1;
      req_valid = 4'h0;
      repeat (6) @(posedge clk);
      #1;
      check("rr_count", rsp_count - base, 6);
      check("queue_empty_rr", sb_q.size(), 0);

      // backpressure: rr_ptr is 2, requesters 0 and 2 pending -> grant 2
      rsp_ready = 1'b0;
      exp_a = 32'h0020_0033;
      exp_b = 32'h0045_0011;
      e = model(2'd2, 8'h20, 8'h45);
      sb_q.push_back(e);
      base = rsp_count;
      req_valid = 4'b0101;
      begin
         bit got;
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) got = 1;
         end
         check("bp_rsp_seen", {31'd0, got}, 32'd1);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_id",    {30'd0, rsp_id},    {30'd0, e.id});
         check("bp_diff",  {24'd0, rsp_diff},  {24'd0, e.diff});
         check("bp_swap",  {31'd0, rsp_swap},  {31'd0, e.swap});
         check("bp_no_grant", {28'd0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);  // handshake edge
      #1;
      req_valid = 4'h0;
      repeat (8) @(posedge clk);
      #1;
      check("bp_one_rsp", rsp_count - base, 1);
      check("bp_idle", {31'd0, busy}, 32'd0);

      // reset during PASS2 of requester 2 (A < B)
      exp_a = 32'h0010_0000;
      exp_b = 32'h0020_0000;
      req_valid = 4'b0100;
      begin
         bit got;
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[2]) got = 1;
         end
         check("abort_grant_seen", {31'd0, got}, 32'd1);
      end
      @(posedge clk);  // accept edge 0
      #1;
      req_valid = 4'h0;
      @(posedge clk);  // edge 1
      @(posedge clk);  // edge 2 -> PASS2
      #1;
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      base = rsp_count;
      rst_n = 1'b0;
      #1;
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort_busy_after", {31'd0, busy}, 32'd0);
      #5 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_stale", rsp_count - base, 0);
      exp_a = 32'h5000_4000;
      exp_b = 32'h1000_0800;
      sb_q.push_back(model(2'd1, 8'h40, 8'h08));
      req_valid = 4'b1010;
      wait_rsp_count(base + 1, 30);
      #1;
      req_valid = 4'h0;
      repeat (6) @(posedge clk);
      #1;
      check("abort_one_rsp", rsp_count - base, 1);
      check("queue_empty_end", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
